multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock, `clock`; reset is synchronous and active-low, on port `reset`, and is asserted when `reset`=0 at a rising `clock` edge.
REQ-002 SHALL have ports, in this order:
- clock  in  1  system clock
- reset  in  1  sync active-low reset
- opcode  in  7  instruction[6:0] taken from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory handshake; the current memory access completes this cycle
- PCWrite  out  1  PC register load enable
- IRWrite  out  1  instruction register load enable
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- ALUSrcA  out  2  ALU A select: 00=PC, 01=rs1, 10=oldPC, 11=zero
- ALUSrcB  out  2  ALU B select: 00=rs2, 01=const 4, 10=imm
- ALUOp  out  2  00=add, 01=sub/compare, 10=funct-decoded
- RegWrite  out  1  register file write enable
- MemtoReg  out  2  writeback select: 00=ALUOut, 01=MDR, 10=PC
- PCSource  out  1  PC source: 0=ALU result, 1=ALUOut
- state  out  4  current state encoding
- illegal  out  1  sticky illegal-opcode flag
- instret  out  32  count of retired instructions

Function
REQ-003 SHALL implement a Moore FSM with these state encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JAL=10, LUI=11, TRAP=12.
REQ-004 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=0.
REQ-005 FETCH SHALL hold, with PCWrite=0 and IRWrite=0, while mem_ready=0.
REQ-006 When mem_ready=1 in FETCH, it SHALL assert PCWrite=1 and IRWrite=1 in that cycle and go to DECODE.
REQ-007 DECODE SHALL drive ALUSrcA=10, ALUSrcB=10, ALUOp=00 to precompute the branch/JAL target.
REQ-008 DECODE SHALL branch on opcode:
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 0000011 or 0100011 -> MEM_ADDR
- 1100011 -> BRANCH
- 1101111 -> JAL
- 0110111 -> LUI
- any other value -> TRAP
REQ-009 EXEC_R SHALL drive ALUSrcA=01, ALUSrcB=00, ALUOp=10 and go to ALU_WB.
REQ-010 EXEC_I SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=10 and go to ALU_WB.
REQ-011 LUI SHALL drive ALUSrcA=11, ALUSrcB=10, ALUOp=00 and go to ALU_WB.
REQ-012 ALU_WB SHALL drive RegWrite=1, MemtoReg=00 and go to FETCH.
REQ-013 MEM_ADDR SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, then go to MEM_READ for a load or MEM_WRITE for a store.
REQ-014 MEM_READ SHALL drive MemRead=1, IorD=1, hold until mem_ready=1, then go to MEM_WB.
REQ-015 MEM_WB SHALL drive RegWrite=1, MemtoReg=01 and go to FETCH.
REQ-016 MEM_WRITE SHALL drive MemWrite=1, IorD=1, hold until mem_ready=1, then go to FETCH.
REQ-017 BRANCH SHALL drive ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=zero, and go to FETCH.
REQ-018 JAL SHALL drive RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=1 and go to FETCH.
REQ-019 TRAP SHALL be absorbing until reset.
- Drives illegal=1.
- All write and request strobes are 0.
- instret is frozen.
REQ-020 Every output not listed for a state SHALL be 0 in that state.
REQ-021 instret SHALL increment by 1 on the clock edge that leaves ALU_WB, MEM_WB, MEM_WRITE (with mem_ready=1), BRANCH or JAL, wrapping 0xFFFFFFFF -> 0.
REQ-022 Minimum latency with mem_ready tied to 1 SHALL be:
- R, I and LUI: 4 cycles
- load: 5 cycles
- store: 4 cycles
- branch and JAL: 3 cycles
REQ-023 A mem_ready pulse outside FETCH, MEM_READ or MEM_WRITE SHALL be ignored.

Reset
REQ-024 While reset=0, all outputs SHALL be 0 except state, which SHALL be FETCH.
REQ-025 On the first edge with reset=1, the FSM SHALL be in FETCH with illegal=0 and instret=0.
REQ-026 Reset asserted in any state, including a MEM_READ or MEM_WRITE stall or TRAP, SHALL abort the current instruction with no further strobes.

Structure
REQ-027 Opcode constants and state encodings SHALL live in the shared RV32 definitions package used by the control and ALU-control blocks.
REQ-028 The instret counter SHALL be one sub-module, instret_counter, with ports clock, reset and inc.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- add (0110011) with mem_ready=1 -> states 0,1,6,8,0; RegWrite=1 only in cycle 4; instret 0->1.
- lw with mem_ready low for 3 cycles in MEM_READ -> MEM_READ held for 4 cycles, MemRead=1 and IorD=1 throughout; RegWrite=1 with MemtoReg=01 once; total 8 cycles.
- beq with zero=1, then with zero=0 -> PCWrite=1 with PCSource=1 in BRANCH for the first, PCWrite=0 for the second; 3 cycles each.
- opcode 0x7F -> TRAP; illegal=1; no strobes for 20 cycles; instret unchanged; reset -> FETCH with illegal=0.
- reset=0 asserted during a MEM_WRITE stall -> MemWrite=0 at the next edge and FETCH afterwards; instret=0.
- instret preset near wrap by forcing 0xFFFFFFFF, then one jal -> instret=0x00000000.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared RV32 definitions for the multicycle core: FSM state encodings,
// base-ISA opcode constants, datapath select codes and the control bundle
// used by the main control FSM (and by the ALU-control decoder).
// No ports; import with `import multicycle_control_pkg::*;`.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_LUI       = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_RS1    = 2'b01;
  localparam logic [1:0] SRCA_OLDPC  = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;

  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] WB_ALUOUT   = 2'b00;
  localparam logic [1:0] WB_MDR      = 2'b01;
  localparam logic [1:0] WB_PC       = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       pc_source;
  } ctrl_t;

  // Dispatch target out of DECODE; anything not in the supported subset traps.
  function automatic state_e decode_next(input logic [6:0] opc);
    state_e nxt;
    case (opc)
      OPC_OP:              nxt = S_EXEC_R;
      OPC_OP_IMM:          nxt = S_EXEC_I;
      OPC_LOAD, OPC_STORE: nxt = S_MEM_ADDR;
      OPC_BRANCH:          nxt = S_BRANCH;
      OPC_JAL:             nxt = S_JAL;
      OPC_LUI:             nxt = S_LUI;
      default:             nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_instret_counter.sv
// Retired-instruction counter.
// Ports: clock, reset (sync active-low), inc (count one retirement this
// cycle), count (32-bit running total, wraps to zero).
module instret_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle RV32 subset core.
// Inputs: clock, reset (sync active-low), opcode (IR[6:0]), zero (ALU flag),
//   mem_ready (current memory access completes this cycle).
// Outputs: datapath strobes/selects (PCWrite, IRWrite, MemRead, MemWrite,
//   IorD, ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemtoReg, PCSource), current
//   state encoding, sticky illegal flag and retired-instruction count.
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | read instruction at PC, PC+4 on mem_ready
// DECODE    | dispatch on opcode, precompute oldPC+imm
// MEM_ADDR  | rs1+imm effective address
// MEM_READ  | load access, held until mem_ready
// MEM_WB    | MDR -> rd
// MEM_WRITE | store access, held until mem_ready
// EXEC_R    | rs1 op rs2
// EXEC_I    | rs1 op imm
// ALU_WB    | ALUOut -> rd
// BRANCH    | compare, take ALUOut target if zero
// JAL       | PC -> rd, jump to ALUOut target
// LUI       | 0 + imm
// TRAP      | illegal opcode, absorbing until reset
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        RegWrite,
  output logic [1:0]  MemtoReg,
  output logic        PCSource,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  state_e      state_q;
  state_e      state_d;
  ctrl_t       ctl;
  ctrl_t       ctl_out;
  logic        retire;
  logic [31:0] count;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctl     = '0;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_a = SRCA_PC;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALUOP_ADD;
        if (mem_ready) begin
          ctl.pc_write = 1'b1;
          ctl.ir_write = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl.alu_src_a = SRCA_OLDPC;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
        state_d       = decode_next(opcode);
      end
      S_EXEC_R: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_RS2;
        ctl.alu_op    = ALUOP_FUNCT;
        state_d       = S_ALU_WB;
      end
      S_EXEC_I: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_FUNCT;
        state_d       = S_ALU_WB;
      end
      S_LUI: begin
        ctl.alu_src_a = SRCA_ZERO;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
        state_d       = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = WB_ALUOUT;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
        // IR is stable here; only load and store opcodes reach this state.
        state_d       = (opcode == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = WB_MDR;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_RS2;
        ctl.alu_op    = ALUOP_SUB;
        ctl.pc_source = 1'b1;
        ctl.pc_write  = zero;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = WB_PC;
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  instret_counter u_instret (
    .clock (clock),
    .reset (reset),
    .inc   (retire & reset),
    .count (count)
  );

  // Reset is synchronous, but outputs must read as idle for the whole time
  // reset is low, not just from the next edge, so gate them combinationally.
  assign ctl_out  = reset ? ctl : '0;
  assign PCWrite  = ctl_out.pc_write;
  assign IRWrite  = ctl_out.ir_write;
  assign MemRead  = ctl_out.mem_read;
  assign MemWrite = ctl_out.mem_write;
  assign IorD     = ctl_out.iord;
  assign ALUSrcA  = ctl_out.alu_src_a;
  assign ALUSrcB  = ctl_out.alu_src_b;
  assign ALUOp    = ctl_out.alu_op;
  assign RegWrite = ctl_out.reg_write;
  assign MemtoReg = ctl_out.mem_to_reg;
  assign PCSource = ctl_out.pc_source;
  assign state    = reset ? state_q : S_FETCH;
  assign illegal  = reset & (state_q == S_TRAP);
  assign instret  = reset ? count : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

  logic        clock;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, PCSource;
  logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, MemtoReg;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] instret;
  logic [14:0] ctl_obs;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control dut (
    .clock     (clock),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .IRWrite   (IRWrite),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IorD      (IorD),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .RegWrite  (RegWrite),
    .MemtoReg  (MemtoReg),
    .PCSource  (PCSource),
    .state     (state),
    .illegal   (illegal),
    .instret   (instret)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {PCWrite,IRWrite,MemRead,MemWrite,IorD,ALUSrcA,ALUSrcB,ALUOp,RegWrite,MemtoReg,PCSource}
  assign ctl_obs = {PCWrite, IRWrite, MemRead, MemWrite, IorD, ALUSrcA, ALUSrcB,
                    ALUOp, RegWrite, MemtoReg, PCSource};

  localparam logic [14:0] C_ZERO    = 15'b0;
  localparam logic [14:0] C_FETCH_W = {1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b01,2'b00,1'b0,2'b00,1'b0};
  localparam logic [14:0] C_FETCH_R = {1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,2'b01,2'b00,1'b0,2'b00,1'b0};
  localparam logic [14:0] C_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b10,2'b00,1'b0,2'b00,1'b0};
  localparam logic [14:0] C_EXEC_R  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b10,1'b0,2'b00,1'b0};
  localparam logic [14:0] C_EXEC_I  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b10,1'b0,2'b00,1'b0};
  localparam logic [14:0] C_LUI     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b10,2'b00,1'b0,2'b00,1'b0};
  localparam logic [14:0] C_ALU_WB  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,2'b00,1'b0};
  localparam logic [14:0] C_MEM_ADR = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b00,1'b0,2'b00,1'b0};
  localparam logic [14:0] C_MEM_RD  = {1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,2'b00,1'b0,2'b00,1'b0};
  localparam logic [14:0] C_MEM_WB  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,2'b01,1'b0};
  localparam logic [14:0] C_MEM_WR  = {1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,2'b00,1'b0,2'b00,1'b0};
  localparam logic [14:0] C_BR_T    = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b01,1'b0,2'b00,1'b1};
  localparam logic [14:0] C_BR_N    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b01,1'b0,2'b00,1'b1};
  localparam logic [14:0] C_JAL     = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,2'b10,1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Lets freshly driven inputs settle, then checks state and control bundle.
  task automatic step(input string tag, input logic [3:0] st, input logic [14:0] ctl);
    #1;
    check({tag, " state"}, {28'd0, state}, {28'd0, st});
    check({tag, " ctl"}, {17'd0, ctl_obs}, {17'd0, ctl});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    opcode    = 7'b0110011;
    zero      = 1'b0;
    mem_ready = 1'b1;
    tick();
    tick();
    step("rst", 4'd0, C_ZERO);
    check("rst illegal", {31'd0, illegal}, 32'd0);
    check("rst instret", instret, 32'd0);

    // add: 0,1,6,8,0
    reset = 1'b1;
    step("add c1", 4'd0, C_FETCH_R);
    check("add instret0", instret, 32'd0);
    tick(); step("add c2", 4'd1, C_DECODE);
    tick(); step("add c3", 4'd6, C_EXEC_R);
    tick(); step("add c4", 4'd8, C_ALU_WB);
    check("add instret pre", instret, 32'd0);
    tick(); step("add done", 4'd0, C_FETCH_R);
    check("add instret", instret, 32'd1);

    // lw with 3 stall cycles in MEM_READ: 8 cycles total
    opcode = 7'b0000011;
    step("lw c1", 4'd0, C_FETCH_R);
    tick(); step("lw c2", 4'd1, C_DECODE);
    tick(); step("lw c3", 4'd2, C_MEM_ADR);
    tick(); mem_ready = 1'b0;
    step("lw c4", 4'd3, C_MEM_RD);
    tick(); step("lw c5", 4'd3, C_MEM_RD);
    tick(); step("lw c6", 4'd3, C_MEM_RD);
    tick(); mem_ready = 1'b1;
    step("lw c7", 4'd3, C_MEM_RD);
    tick(); step("lw c8", 4'd4, C_MEM_WB);
    tick(); step("lw done", 4'd0, C_FETCH_R);
    check("lw instret", instret, 32'd2);

    // beq taken, then not taken
    opcode = 7'b1100011;
    zero   = 1'b1;
    step("beqT c1", 4'd0, C_FETCH_R);
    tick(); step("beqT c2", 4'd1, C_DECODE);
    tick(); step("beqT c3", 4'd9, C_BR_T);
    tick(); step("beqT done", 4'd0, C_FETCH_R);
    check("beqT instret", instret, 32'd3);
    zero = 1'b0;
    tick(); step("beqN c2", 4'd1, C_DECODE);
    tick(); step("beqN c3", 4'd9, C_BR_N);
    tick(); step("beqN done", 4'd0, C_FETCH_R);
    check("beqN instret", instret, 32'd4);

    // illegal opcode -> TRAP, absorbing, no strobes
    opcode = 7'h7F;
    tick(); step("trap c2", 4'd1, C_DECODE);
    tick();
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero      = 1'($urandom_range(0, 1));
      opcode    = (i == 5) ? 7'b0110011 : 7'h7F;
      step("trap hold", 4'd12, C_ZERO);
      check("trap illegal", {31'd0, illegal}, 32'd1);
      check("trap instret", instret, 32'd4);
      tick();
    end
    reset = 1'b0;
    step("trap rst", 4'd0, C_ZERO);
    check("trap rst illegal", {31'd0, illegal}, 32'd0);
    tick();
    reset     = 1'b1;
    mem_ready = 1'b1;
    zero      = 1'b0;
    opcode    = 7'b0010011;
    step("post trap", 4'd0, C_FETCH_R);
    check("post trap illegal", {31'd0, illegal}, 32'd0);
    check("post trap instret", instret, 32'd0);

    // addi then lui
    tick(); step("addi c2", 4'd1, C_DECODE);
    tick(); step("addi c3", 4'd7, C_EXEC_I);
    tick(); step("addi c4", 4'd8, C_ALU_WB);
    opcode = 7'b0110111;
    tick(); step("lui c1", 4'd0, C_FETCH_R);
    check("addi instret", instret, 32'd1);
    tick(); step("lui c2", 4'd1, C_DECODE);
    tick(); step("lui c3", 4'd11, C_LUI);
    tick(); step("lui c4", 4'd8, C_ALU_WB);
    tick(); step("lui done", 4'd0, C_FETCH_R);
    check("lui instret", instret, 32'd2);

    // store stalled in MEM_WRITE, then aborted by reset
    opcode = 7'b0100011;
    tick(); step("sw c2", 4'd1, C_DECODE);
    // mem_ready pulse in DECODE must not matter
    tick(); step("sw c3", 4'd2, C_MEM_ADR);
    tick(); mem_ready = 1'b0;
    step("sw stall1", 4'd5, C_MEM_WR);
    tick(); step("sw stall2", 4'd5, C_MEM_WR);
    check("sw stall instret", instret, 32'd2);
    reset = 1'b0;
    step("sw abort", 4'd0, C_ZERO);
    tick(); step("sw abort edge", 4'd0, C_ZERO);
    reset = 1'b1;
    step("sw after", 4'd0, C_FETCH_W);
    check("sw after instret", instret, 32'd0);

    // instret wrap via jal
    force dut.u_instret.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_instret.count_q;
    tick(); step("wrap hold", 4'd0, C_FETCH_W);
    check("wrap preset", instret, 32'hFFFF_FFFF);
    opcode    = 7'b1101111;
    mem_ready = 1'b1;
    step("jal c1", 4'd0, C_FETCH_R);
    tick(); step("jal c2", 4'd1, C_DECODE);
    tick(); step("jal c3", 4'd10, C_JAL);
    check("jal pre instret", instret, 32'hFFFF_FFFF);
    tick(); step("jal done", 4'd0, C_FETCH_R);
    check("wrap instret", instret, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
